// File: rtl/arbitration_submodule_mc.sv
// Per-channel processor-to-bus request FSMs (IDLE/REQ/OWN/DONE), best case p_ready 3 cycles after the request edge.
// Backpressure: a channel waits in REQ for bus_grant (optional timeout) and in OWN for bus_ready; core inputs ignored meanwhile.
module arbitration_submodule_mc #(
  parameter int NCH = 2,
  parameter int AW  = 30,
  parameter int DW  = 32,
  parameter int SW  = 4,
  parameter int TMO = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]    p_read,
  input  logic [NCH*SW-1:0] p_write,
  input  logic [NCH*AW-1:0] p_addr,
  input  logic [NCH*DW-1:0] p_wdata,
  output logic [NCH*DW-1:0] p_rdata,
  output logic [NCH-1:0]    p_ready,
  output logic [NCH-1:0]    p_err,
  output logic [NCH-1:0]    bus_read,
  output logic [NCH*SW-1:0] bus_write,
  output logic [NCH*AW-1:0] bus_addr,
  output logic [NCH*DW-1:0] bus_wdata,
  input  logic [NCH*DW-1:0] bus_rdata,
  input  logic [NCH-1:0]    bus_ready,
  output logic [NCH-1:0]    bus_rq,
  input  logic [NCH-1:0]    bus_grant
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, OWN, DONE} state_t;

  for (genvar i = 0; i < NCH; i++) begin : gChan
    state_t        state;
    logic [AW-1:0] addrHold;
    logic [DW-1:0] wdataHold;
    logic [SW-1:0] strbHold;
    logic          readHold;
    logic [CW-1:0] waitCnt;
    logic          readyReg;
    logic          errReg;
    logic [DW-1:0] rdataReg;
    logic [SW-1:0] strbIn;
    logic          own;

    assign strbIn = p_write[i*SW +: SW];
    assign own    = (state == OWN);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        addrHold  <= '0;
        wdataHold <= '0;
        strbHold  <= '0;
        readHold  <= 1'b0;
        waitCnt   <= '0;
        readyReg  <= 1'b0;
        errReg    <= 1'b0;
        rdataReg  <= '0;
      end else begin
        readyReg <= 1'b0;
        case (state)
          IDLE: begin
            // A timeout returns here with p_ready high; the requester still
            // holds its request on that edge, so it must not restart.
            if (!readyReg && (p_read[i] || strbIn != '0)) begin
              addrHold  <= p_addr[i*AW +: AW];
              wdataHold <= p_wdata[i*DW +: DW];
              strbHold  <= strbIn;
              readHold  <= p_read[i] && (strbIn == '0);
              errReg    <= 1'b0;
              waitCnt   <= '0;
              state     <= REQ;
            end
          end
          REQ: begin
            if (bus_grant[i]) begin
              state <= OWN;
            end else if (TMO != 0 && waitCnt == CW'(TMO)) begin
              errReg   <= 1'b1;
              readyReg <= 1'b1;
              state    <= IDLE;
            end else begin
              waitCnt <= waitCnt + CW'(1);
            end
          end
          OWN: begin
            if (!bus_grant[i]) begin
              waitCnt <= '0;
              state   <= REQ;
            end else if (bus_ready[i]) begin
              if (readHold) rdataReg <= bus_rdata[i*DW +: DW];
              readyReg <= 1'b1;
              state    <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
        endcase
      end
    end

    assign bus_rq[i]               = (state == REQ) || own;
    assign bus_read[i]             = own & readHold;
    assign bus_write[i*SW +: SW]   = own ? strbHold : '0;
    assign bus_addr[i*AW +: AW]    = own ? addrHold : '0;
    assign bus_wdata[i*DW +: DW]   = own ? wdataHold : '0;
    assign p_ready[i]              = readyReg;
    assign p_err[i]                = errReg;
    assign p_rdata[i*DW +: DW]     = rdataReg;
  end

endmodule

// File: tb/tb_arbitration_submodule_mc.sv
// Bench for arbitration_submodule_mc: directed scenarios plus randomized transactions,
// expectations from a transaction-level model (last read data per channel, cycle schedule).
module tb_arbitration_submodule_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pRead;
  logic [7:0]  pWrite;
  logic [59:0] pAddr;
  logic [63:0] pWdata;
  logic [63:0] pRdata;
  logic [1:0]  pReady;
  logic [1:0]  pErr;
  logic [1:0]  busRead;
  logic [7:0]  busWrite;
  logic [59:0] busAddr;
  logic [63:0] busWdata;
  logic [63:0] busRdata;
  logic [1:0]  busReady;
  logic [1:0]  busRq;
  logic [1:0]  busGrant;

  logic        rdC   [2];
  logic [3:0]  wrC   [2];
  logic [29:0] adC   [2];
  logic [31:0] wdC   [2];
  logic [31:0] brdC  [2];
  logic        brdyC [2];
  logic        gntC  [2];

  assign pRead    = {rdC[1], rdC[0]};
  assign pWrite   = {wrC[1], wrC[0]};
  assign pAddr    = {adC[1], adC[0]};
  assign pWdata   = {wdC[1], wdC[0]};
  assign busRdata = {brdC[1], brdC[0]};
  assign busReady = {brdyC[1], brdyC[0]};
  assign busGrant = {gntC[1], gntC[0]};

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expRdata [2];

  arbitration_submodule_mc #(
    .NCH(2), .AW(30), .DW(32), .SW(4), .TMO(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p_read(pRead), .p_write(pWrite), .p_addr(pAddr), .p_wdata(pWdata),
    .p_rdata(pRdata), .p_ready(pReady), .p_err(pErr),
    .bus_read(busRead), .bus_write(busWrite), .bus_addr(busAddr), .bus_wdata(busWdata),
    .bus_rdata(busRdata), .bus_ready(busReady), .bus_rq(busRq), .bus_grant(busGrant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int ch, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s ch%0d observed=%0h expected=%0h", tag, ch, obs, exp);
    end
  endtask

  task automatic expectIsolated(input int ch);
    chk("bus_read_zero",  ch, busRead[ch], 0);
    chk("bus_write_zero", ch, busWrite[ch*4 +: 4], 0);
    chk("bus_addr_zero",  ch, busAddr[ch*30 +: 30], 0);
    chk("bus_wdata_zero", ch, busWdata[ch*32 +: 32], 0);
  endtask

  task automatic expectOwn(input int ch, input logic rd, input logic [3:0] wr,
                           input logic [29:0] a, input logic [31:0] wd);
    chk("own_rq",        ch, busRq[ch], 1);
    chk("own_ready",     ch, pReady[ch], 0);
    chk("own_bus_read",  ch, busRead[ch], rd);
    chk("own_bus_write", ch, busWrite[ch*4 +: 4], wr);
    chk("own_bus_addr",  ch, busAddr[ch*30 +: 30], a);
    chk("own_bus_wdata", ch, busWdata[ch*32 +: 32], wd);
  endtask

  // One transaction: grant after d cycles; gap>0 drops grant for gap cycles mid-OWN.
  task automatic runTxn(input int ch, input logic rd, input logic [3:0] wr, input logic [29:0] a,
                        input logic [31:0] wd, input logic [31:0] rdv, input int d, input int gap);
    logic expRd;
    expRd = rd && (wr == 4'd0);
    rdC[ch] = rd; wrC[ch] = wr; adC[ch] = a; wdC[ch] = wd;
    tick();
    chk("rq_after_req", ch, busRq[ch], 1);
    chk("err_cleared",  ch, pErr[ch], 0);
    chk("ready_in_req", ch, pReady[ch], 0);
    expectIsolated(ch);
    adC[ch] = ~a; wdC[ch] = ~wd;
    for (int k = 0; k < d; k++) begin
      tick();
      chk("rq_wait",    ch, busRq[ch], 1);
      chk("ready_wait", ch, pReady[ch], 0);
      expectIsolated(ch);
    end
    gntC[ch] = 1'b1; brdyC[ch] = (gap == 0); brdC[ch] = rdv;
    tick();
    expectOwn(ch, expRd, wr, a, wd);
    if (gap > 0) begin
      tick();
      expectOwn(ch, expRd, wr, a, wd);
      gntC[ch] = 1'b0; brdyC[ch] = 1'b1; brdC[ch] = ~rdv;
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_rq",    ch, busRq[ch], 1);
        chk("gap_ready", ch, pReady[ch], 0);
        expectIsolated(ch);
      end
      gntC[ch] = 1'b1; brdC[ch] = rdv;
      tick();
      expectOwn(ch, expRd, wr, a, wd);
    end
    tick();
    if (expRd) expRdata[ch] = rdv;
    chk("done_ready", ch, pReady[ch], 1);
    chk("done_rq",    ch, busRq[ch], 0);
    chk("done_err",   ch, pErr[ch], 0);
    chk("done_rdata", ch, pRdata[ch*32 +: 32], expRdata[ch]);
    expectIsolated(ch);
    tick();
    rdC[ch] = 1'b0; wrC[ch] = 4'd0; gntC[ch] = 1'b0; brdyC[ch] = 1'b0;
    chk("post_ready", ch, pReady[ch], 0);
    chk("post_rq",    ch, busRq[ch], 0);
    chk("post_rdata", ch, pRdata[ch*32 +: 32], expRdata[ch]);
    tick();
    chk("idle_rq",    ch, busRq[ch], 0);
    chk("idle_ready", ch, pReady[ch], 0);
  endtask

  task automatic runTimeout(input int ch, input logic [29:0] a);
    rdC[ch] = 1'b1; wrC[ch] = 4'd0; adC[ch] = a; gntC[ch] = 1'b0; brdyC[ch] = 1'b1;
    tick();
    chk("tmo_rq_rise", ch, busRq[ch], 1);
    for (int k = 1; k <= 255; k++) begin
      tick();
      chk("tmo_ready_low", ch, pReady[ch], 0);
      chk("tmo_rq_high",   ch, busRq[ch], 1);
      chk("tmo_bus_addr",  ch, busAddr[ch*30 +: 30], 0);
      chk("tmo_bus_read",  ch, busRead[ch], 0);
    end
    tick();
    chk("tmo_ready_pulse", ch, pReady[ch], 1);
    chk("tmo_err",         ch, pErr[ch], 1);
    chk("tmo_rq_low",      ch, busRq[ch], 0);
    chk("tmo_rdata_kept",  ch, pRdata[ch*32 +: 32], expRdata[ch]);
    expectIsolated(ch);
    tick();
    rdC[ch] = 1'b0; brdyC[ch] = 1'b0;
    chk("tmo_ready_single", ch, pReady[ch], 0);
    chk("tmo_no_restart",   ch, busRq[ch], 0);
    chk("tmo_err_held",     ch, pErr[ch], 1);
    tick();
    chk("tmo_idle_rq",      ch, busRq[ch], 0);
  endtask

  task automatic expectAllZero(input string tag);
    for (int c = 0; c < 2; c++) begin
      chk({tag, "_rq"},    c, busRq[c], 0);
      chk({tag, "_ready"}, c, pReady[c], 0);
      chk({tag, "_err"},   c, pErr[c], 0);
      chk({tag, "_rdata"}, c, pRdata[c*32 +: 32], 0);
      expectIsolated(c);
    end
  endtask

  int          rch;
  logic        rrd;
  logic [3:0]  rwr;
  logic [29:0] ra;

  initial begin
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rdC[c] = 0; wrC[c] = 0; adC[c] = 0; wdC[c] = 0;
      brdC[c] = 0; brdyC[c] = 0; gntC[c] = 0; expRdata[c] = 0;
    end
    tick();
    expectAllZero("reset");
    rst_n = 1'b1;
    tick();

    // ch0 read addr 31, grant after 5 cycles, bus_rdata 63
    runTxn(0, 1'b1, 4'd0, 30'd31, 32'h0, 32'd63, 5, 0);
    // ch0 write strobe 0100, grant drops mid-OWN and returns
    runTxn(0, 1'b0, 4'b0100, 30'h1234, 32'd127, 32'hDEAD_BEEF, 2, 3);
    // minimum latency, ch1 read
    runTxn(1, 1'b1, 4'd0, 30'h2AAA, 32'h5, 32'hCAFE_0001, 0, 0);
    // ch1 timeout, then a fresh request clears p_err
    runTimeout(1, 30'h0ABC);
    runTxn(1, 1'b1, 4'd0, 30'h77, 32'h0, 32'h1357_9BDF, 1, 0);
    // read and write together: write wins
    runTxn(0, 1'b1, 4'b0001, 30'h55, 32'hA5A5_A5A5, 32'hFFFF_0000, 1, 0);

    // both channels concurrently, grants in opposite orders
    fork
      runTxn(0, 1'b1, 4'd0, 30'h100, 32'h0, 32'h0000_1111, 1, 0);
      runTxn(1, 1'b1, 4'd0, 30'h200, 32'h0, 32'h0000_2222, 4, 0);
    join
    fork
      runTxn(0, 1'b0, 4'b1111, 30'h300, 32'h3333_3333, 32'h9, 4, 0);
      runTxn(1, 1'b1, 4'd0, 30'h400, 32'h0, 32'h4444_4444, 1, 1);
    join

    // reset while in OWN
    rdC[0] = 1'b1; adC[0] = 30'h3FF; wdC[0] = 32'h0; gntC[0] = 1'b1; brdyC[0] = 1'b0;
    tick();
    tick();
    expectOwn(0, 1'b1, 4'd0, 30'h3FF, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    expRdata[0] = 0; expRdata[1] = 0;
    expectAllZero("arst");
    brdyC[0] = 1'b1;
    tick();
    expectAllZero("arst_hold");
    rdC[0] = 1'b0; gntC[0] = 1'b0; brdyC[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 0, pReady[0], 0);
    chk("post_rst_rq",    0, busRq[0], 0);
    runTxn(0, 1'b1, 4'd0, 30'h3FF, 32'h0, 32'h0BAD_F00D, 0, 0);

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      rch = $urandom_range(0, 1);
      rrd = 1'($urandom);
      rwr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      if (rwr == 4'd0) rrd = 1'b1;
      ra  = 30'($urandom);
      runTxn(rch, rrd, rwr, ra, $urandom, $urandom, $urandom_range(0, 6),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
